// File: rtl/gray_window_3x3_gen_pkg.sv
// Shared types and constants for the 3x3 gray window generator.
package gray_window_3x3_gen_pkg;
    localparam logic [11:0] DEF_HDISP  = 12'd640;
    localparam logic [11:0] DEF_VDISP  = 12'd480;
    localparam int          MATRIX_LAT = 2;
    localparam int          FLUSH_GAP  = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_e;

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
    } col_t;

    typedef struct packed {
        logic vsync;
        logic top_f;
        logic bot_f;
        logic left_f;
        logic right_f;
        col_t c1;
        col_t c2;
        col_t c3;
    } win_t;
endpackage

// File: rtl/gray_window_3x3_gen_if.sv
// Pixel-in / window-out bundle; master is the video source, slave is the generator.
interface gray_window_3x3_gen_if;
    logic       per_img_vsync;
    logic       per_img_href;
    logic [7:0] per_img_gray;
    logic       matrix_img_vsync;
    logic       matrix_img_href;
    logic       matrix_top_edge_flag;
    logic       matrix_bottom_edge_flag;
    logic       matrix_left_edge_flag;
    logic       matrix_right_edge_flag;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;

    modport master (
        output per_img_vsync, per_img_href, per_img_gray,
        input  matrix_img_vsync, matrix_img_href,
        input  matrix_top_edge_flag, matrix_bottom_edge_flag,
        input  matrix_left_edge_flag, matrix_right_edge_flag,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );

    modport slave (
        input  per_img_vsync, per_img_href, per_img_gray,
        output matrix_img_vsync, matrix_img_href,
        output matrix_top_edge_flag, matrix_bottom_edge_flag,
        output matrix_left_edge_flag, matrix_right_edge_flag,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );
endinterface

// File: rtl/gray_window_3x3_gen_line_buffer.sv
// One line of 8-bit pixels; asynchronous read gives read-before-write at the same address.
module gray_line_buffer
    import gray_window_3x3_gen_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_HDISP,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end
endmodule

// File: rtl/gray_window_3x3_gen.sv
// 3x3 neighbourhood generator: two cascaded line buffers, 3-tap column shift, edge replication.
module gray_window_3x3_gen
    import gray_window_3x3_gen_pkg::*;
#(
    parameter int unsigned IMG_HDISP = DEF_HDISP,
    parameter int unsigned IMG_VDISP = DEF_VDISP
) (
    input  logic                   clk,
    input  logic                   rst,
    gray_window_3x3_gen_if.slave   io
);
    localparam int             CW       = $clog2(IMG_HDISP);
    localparam int             RW       = $clog2(IMG_VDISP);
    localparam logic [CW-1:0]  COL_LAST = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_VDISP - 1);
    localparam logic [1:0]     GAP_LAST = 2'(FLUSH_GAP - 2);

    state_e              state_q, state_d;
    logic [CW-1:0]       in_col_q, in_col_d, col1_q, col1_d;
    logic [RW-1:0]       in_row_q, in_row_d, row1_q, row1_d, orow;
    logic [1:0]          gap_q, gap_d;
    logic                pend_q, pend_d, vs_prev_q, vs_prev_d, href_prev_q, href_prev_d;
    logic [MATRIX_LAT:1] vld_pipe_q, vld_pipe_d;
    col_t                tap_a_q, tap_a_d, tap_b_q, tap_b_d, live;
    win_t                win_q, win_d;
    logic [7:0]          lb0_rd, lb1_rd;
    logic                vs_rise, href_fall, href_int, lb_we, flushing;

    assign flushing  = (state_q == ST_FLUSH);
    assign vs_rise   = io.per_img_vsync & ~vs_prev_q;
    assign href_fall = href_prev_q & ~io.per_img_href;
    assign lb_we     = io.per_img_href & ~pend_q & ((state_q == ST_FILL) | (state_q == ST_RUN));
    assign href_int  = flushing | (io.per_img_href & ~pend_q & (state_q == ST_RUN));
    assign orow      = flushing ? ROW_LAST : in_row_q - 1'b1;

    gray_line_buffer #(.DEPTH(IMG_HDISP)) u_lb0 (
        .clk(clk), .we(lb_we), .addr(in_col_q), .wdata(io.per_img_gray), .rdata(lb0_rd)
    );
    gray_line_buffer #(.DEPTH(IMG_HDISP)) u_lb1 (
        .clk(clk), .we(lb_we), .addr(in_col_q), .wdata(lb0_rd), .rdata(lb1_rd)
    );

    // Vertical replication is applied as the column enters the shifter.
    always_comb begin
        live.mid = lb0_rd;
        live.top = (orow == '0) ? lb0_rd : lb1_rd;
        live.bot = flushing ? lb0_rd : io.per_img_gray;
    end

    always_comb begin
        state_d     = state_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        gap_d       = gap_q;
        pend_d      = pend_q;
        vs_prev_d   = io.per_img_vsync;
        href_prev_d = io.per_img_href;
        if (href_int || lb_we) in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
        unique case (state_q)
            ST_IDLE: if (vs_rise) begin
                state_d  = ST_FILL;
                in_col_d = '0;
                in_row_d = '0;
                gap_d    = '0;
                pend_d   = 1'b0;
            end
            ST_FILL: if (href_fall) begin
                state_d  = ST_RUN;
                in_row_d = in_row_q + 1'b1;
            end
            ST_RUN: begin
                if (pend_q) begin
                    gap_d = gap_q + 2'd1;
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_FLUSH;
                        gap_d   = '0;
                        pend_d  = 1'b0;
                    end
                end else if (href_fall) begin
                    if (in_row_q == ROW_LAST) pend_d = 1'b1;
                    else                      in_row_d = in_row_q + 1'b1;
                end
            end
            ST_FLUSH: if (in_col_q == COL_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Window for column col1 is formed once column col1+1 is live on the read port.
    always_comb begin
        tap_a_d    = href_int ? live     : tap_a_q;
        tap_b_d    = href_int ? tap_a_q  : tap_b_q;
        col1_d     = href_int ? in_col_q : col1_q;
        row1_d     = href_int ? orow     : row1_q;
        vld_pipe_d = {vld_pipe_q[MATRIX_LAT-1:1], href_int};
        win_d       = '0;
        win_d.vsync = (state_q != ST_IDLE) | (|vld_pipe_q);
        if (vld_pipe_q[1]) begin
            win_d.c1      = (col1_q == '0) ? tap_a_q : tap_b_q;
            win_d.c2      = tap_a_q;
            win_d.c3      = (col1_q == COL_LAST) ? tap_a_q : live;
            win_d.top_f   = (row1_q == '0);
            win_d.bot_f   = (row1_q == ROW_LAST);
            win_d.left_f  = (col1_q == '0);
            win_d.right_f = (col1_q == COL_LAST);
        end
    end

    // vs_prev resets high so a vsync still high after reset is not taken as a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_col_q    <= '0;
            in_row_q    <= '0;
            col1_q      <= '0;
            row1_q      <= '0;
            gap_q       <= '0;
            pend_q      <= 1'b0;
            vs_prev_q   <= 1'b1;
            href_prev_q <= 1'b0;
            vld_pipe_q  <= '0;
            tap_a_q     <= '0;
            tap_b_q     <= '0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            col1_q      <= col1_d;
            row1_q      <= row1_d;
            gap_q       <= gap_d;
            pend_q      <= pend_d;
            vs_prev_q   <= vs_prev_d;
            href_prev_q <= href_prev_d;
            vld_pipe_q  <= vld_pipe_d;
            tap_a_q     <= tap_a_d;
            tap_b_q     <= tap_b_d;
            win_q       <= win_d;
        end
    end

    assign io.matrix_img_vsync        = win_q.vsync;
    assign io.matrix_img_href         = vld_pipe_q[MATRIX_LAT];
    assign io.matrix_top_edge_flag    = win_q.top_f;
    assign io.matrix_bottom_edge_flag = win_q.bot_f;
    assign io.matrix_left_edge_flag   = win_q.left_f;
    assign io.matrix_right_edge_flag  = win_q.right_f;
    assign io.matrix_p11 = win_q.c1.top;
    assign io.matrix_p12 = win_q.c2.top;
    assign io.matrix_p13 = win_q.c3.top;
    assign io.matrix_p21 = win_q.c1.mid;
    assign io.matrix_p22 = win_q.c2.mid;
    assign io.matrix_p23 = win_q.c3.mid;
    assign io.matrix_p31 = win_q.c1.bot;
    assign io.matrix_p32 = win_q.c2.bot;
    assign io.matrix_p33 = win_q.c3.bot;
endmodule

// File: tb/tb_gray_window_3x3_gen.sv
// Directed frames against an edge-replicating window model with cycle-accurate scoreboard.
module tb_gray_window_3x3_gen;
    localparam int H = 8;
    localparam int V = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_window_3x3_gen_if io();
    gray_window_3x3_gen #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (.clk(clk), .rst(rst), .io(io));

    typedef struct {
        logic [75:0] win;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_vs_rise = 0;
    int          exp_vs_fall = 0;
    int          hcount = 0;
    logic        mvs_prev = 1'b0;
    logic [75:0] owin;
    logic [7:0]  img [V][H];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic int clampv(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [75:0] exp_win(input int r, input int c);
        logic [75:0] w = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                w = {w[67:0], img[clampv(r + dr, V - 1)][clampv(c + dc, H - 1)]};
        w = {w[71:0], r == 0, r == V - 1, c == 0, c == H - 1};
        return w;
    endfunction

    function automatic logic [75:0] obs_win();
        return {io.matrix_p11, io.matrix_p12, io.matrix_p13,
                io.matrix_p21, io.matrix_p22, io.matrix_p23,
                io.matrix_p31, io.matrix_p32, io.matrix_p33,
                io.matrix_top_edge_flag, io.matrix_bottom_edge_flag,
                io.matrix_left_edge_flag, io.matrix_right_edge_flag};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            owin = obs_win();
            if (io.matrix_img_vsync && !mvs_prev) begin
                chk("vsync_rise_cycle", 80'(cyc), 80'(exp_vs_rise));
                hcount = 0;
            end
            if (!io.matrix_img_vsync && mvs_prev) begin
                chk("vsync_fall_cycle", 80'(cyc), 80'(exp_vs_fall));
                chk("href_count", 80'(hcount), 80'(H * V));
            end
            if (io.matrix_img_href) begin
                hcount++;
                if (sb.size() == 0) chk("extra_href", 80'(1), 80'(0));
                else begin
                    e = sb.pop_front();
                    chk("window", 80'(owin), 80'(e.win));
                    chk("latency", 80'(cyc), 80'(e.cyc));
                end
            end else begin
                chk("flags_idle", 80'(owin[3:0]), 80'(0));
            end
        end
        mvs_prev = io.matrix_img_vsync;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit vs, input bit hr, input logic [7:0] px);
        io.per_img_vsync = vs;
        io.per_img_href  = hr;
        io.per_img_gray  = px;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk(tag, {2'b00, io.matrix_img_vsync, io.matrix_img_href, obs_win()}, 80'(0));
    endtask

    task automatic abort_reset();
        step();
        rst = 1'b1;
        set_in(0, 0, 8'h00);
        repeat (2) begin
            step();
            check_all_zero("reset_midframe_zero");
        end
        step();
        rst = 1'b0;
        sb.delete();
        repeat (3) step();
    endtask

    // kind 0: ramp 16*r+c, kind 1: constant 200
    task automatic drive_frame(input int kind, input bit spurious, input int abort_row);
        int tl = 0;
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                img[r][c] = (kind == 0) ? 8'(16 * r + c) : 8'd200;
        step();
        set_in(1, 0, 8'h00);
        exp_vs_rise = cyc + 2;
        repeat (4) step();
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                step();
                set_in(1, 1, img[r][c]);
                if (r == abort_row && c == 3) begin
                    abort_reset();
                    return;
                end
                if (r > 0) sb.push_back('{exp_win(r - 1, c), cyc + 2});
                tl = cyc;
            end
            if (r < V - 1) repeat (6) begin
                step();
                set_in(1, 0, 8'h00);
            end
        end
        // flush row: internal href begins 4 cycles after the first low cycle
        for (int c = 0; c < H; c++) sb.push_back('{exp_win(V - 1, c), tl + 7 + c});
        exp_vs_fall = tl + H + 8;
        for (int i = 1; i <= H + 12; i++) begin
            step();
            set_in(1, spurious && i >= 7 && i <= 9, 8'hEE);
        end
        step();
        set_in(0, 0, 8'h00);
        repeat (4) step();
    endtask

    initial begin
        set_in(0, 0, 8'h00);
        rst = 1'b1;
        repeat (3) step();
        check_all_zero("reset_state");
        step();
        rst = 1'b0;
        drive_frame(0, 0, -1);
        drive_frame(1, 0, -1);
        drive_frame(0, 0, 2);
        drive_frame(0, 0, -1);
        drive_frame(0, 1, -1);
        repeat (4) step();
        chk("scoreboard_empty", 80'(sb.size()), 80'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
